// File: rtl/forney_ctrl.sv
// Forney front-end scheduler: captures per-lane Chien hits into lane FIFOs plus an
// event FIFO of hit masks, then issues one item per cycle, highest lane first per event.
module forney_ctrl #(
  parameter int LANES        = 32,
  parameter int W            = 10,
  parameter int T            = 11,
  parameter int U_LEN        = T + 1,
  parameter int POS_W        = 10,
  parameter int LANE_FIFO_AW = 4,
  parameter int EVT_FIFO_AW  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [LANES-1:0]                      hit_mask_i,
  input  logic [LANES-1:0][POS_W-1:0]           pos_bus_i,
  input  logic [LANES-1:0][0:U_LEN-1][W-1:0]    u_vec_i,
  input  logic                                  s1_rdy_i,
  output logic                                  vld_o,
  output logic [POS_W-1:0]                      pos_o,
  output logic [0:U_LEN-1][W-1:0]               u_vec_o
);

  localparam int LDEPTH = 1 << LANE_FIFO_AW;
  localparam int EDEPTH = 1 << EVT_FIFO_AW;
  localparam int SEL_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [0:U_LEN-1][W-1:0] uvec_t;

  logic              clr;
  logic              accept;
  logic              issue;
  logic              evt_pop;
  logic              evt_full;
  logic              evt_empty;
  logic [LANES-1:0]  evt_head;
  logic [LANES-1:0]  lane_full;
  logic [LANES-1:0]  lane_push;
  logic [LANES-1:0]  lane_pop;
  logic [POS_W-1:0]  head_pos [LANES];
  uvec_t             head_u   [LANES];

  logic [LANES-1:0]  rem_q, rem_d, rem_clr;
  logic [SEL_W-1:0]  sel;
  logic              vld_q, vld_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  uvec_t             u_q, u_d;

  assign clr = rst_i | flush_i;

  // Whole event is dropped if any target FIFO is full (full ignores a same-cycle pop).
  assign accept    = (|hit_mask_i) && !flush_i && !evt_full && ((hit_mask_i & lane_full) == '0);
  assign lane_push = accept ? hit_mask_i : '0;

  // ---------------- event FIFO ----------------
  logic [LANES-1:0]       evt_mem [EDEPTH];
  logic [EVT_FIFO_AW:0]   evt_wr_q, evt_rd_q;

  assign evt_empty = (evt_wr_q == evt_rd_q);
  assign evt_full  = (evt_wr_q[EVT_FIFO_AW] != evt_rd_q[EVT_FIFO_AW]) &&
                     (evt_wr_q[EVT_FIFO_AW-1:0] == evt_rd_q[EVT_FIFO_AW-1:0]);
  assign evt_head  = evt_mem[evt_rd_q[EVT_FIFO_AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (accept) evt_mem[evt_wr_q[EVT_FIFO_AW-1:0]] <= hit_mask_i;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      evt_wr_q <= '0;
      evt_rd_q <= '0;
    end else begin
      if (accept)  evt_wr_q <= evt_wr_q + 1'b1;
      if (evt_pop) evt_rd_q <= evt_rd_q + 1'b1;
    end
  end

  // ---------------- per-lane FIFOs ----------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [POS_W-1:0]      pos_mem [LDEPTH];
    uvec_t                 u_mem   [LDEPTH];
    logic [LANE_FIFO_AW:0] wr_q, rd_q;

    always_ff @(posedge clk_i) begin
      if (lane_push[gi]) begin
        pos_mem[wr_q[LANE_FIFO_AW-1:0]] <= pos_bus_i[gi];
        u_mem[wr_q[LANE_FIFO_AW-1:0]]   <= u_vec_i[gi];
      end
    end

    always_ff @(posedge clk_i) begin
      if (clr) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (lane_push[gi]) wr_q <= wr_q + 1'b1;
        if (lane_pop[gi])  rd_q <= rd_q + 1'b1;
      end
    end

    assign lane_full[gi] = (wr_q[LANE_FIFO_AW] != rd_q[LANE_FIFO_AW]) &&
                           (wr_q[LANE_FIFO_AW-1:0] == rd_q[LANE_FIFO_AW-1:0]);
    assign head_pos[gi]  = pos_mem[rd_q[LANE_FIFO_AW-1:0]];
    assign head_u[gi]    = u_mem[rd_q[LANE_FIFO_AW-1:0]];
    assign lane_pop[gi]  = issue && (sel == SEL_W'(gi));
  end

  // ---------------- scheduler ----------------
  always_comb begin
    sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rem_q[i]) sel = SEL_W'(i);
    end
  end

  assign issue   = (rem_q != '0) && (!vld_q || s1_rdy_i);
  assign rem_clr = rem_q & ~(LANES'(1) << sel);
  // Lookahead: fetch the next mask in the same cycle the last lane of rem issues.
  assign evt_pop = !evt_empty && ((rem_q == '0) || (issue && (rem_clr == '0)));

  always_comb begin
    rem_d = rem_q;
    if (evt_pop)    rem_d = evt_head;
    else if (issue) rem_d = rem_clr;
  end

  always_comb begin
    vld_d = vld_q;
    pos_d = pos_q;
    u_d   = u_q;
    if (issue) begin
      vld_d = 1'b1;
      pos_d = head_pos[sel];
      for (int k = 0; k < U_LEN; k++) u_d[k] = head_u[sel][U_LEN-1-k];
    end else if (s1_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      rem_q <= '0;
      vld_q <= 1'b0;
      pos_q <= '0;
      u_q   <= '0;
    end else begin
      rem_q <= rem_d;
      vld_q <= vld_d;
      pos_q <= pos_d;
      u_q   <= u_d;
    end
  end

  assign vld_o   = vld_q;
  assign pos_o   = pos_q;
  assign u_vec_o = u_q;

endmodule

// File: tb/tb_forney_ctrl.sv
// Directed bench for forney_ctrl: latency, lane ordering, back-to-back events,
// backpressure, overflow drop, flush and mid-stream reset.
module tb_forney_ctrl;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic [31:0]               hit_mask;
  logic [31:0][9:0]          pos_bus;
  logic [31:0][0:11][9:0]    u_vec;
  logic                      s1_rdy;
  logic                      vld_o;
  logic [9:0]                pos_o;
  logic [0:11][9:0]          u_vec_o;

  int n_total = 0;
  int n_pass  = 0;

  forney_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .hit_mask_i (hit_mask),
    .pos_bus_i  (pos_bus),
    .u_vec_i    (u_vec),
    .s1_rdy_i   (s1_rdy),
    .vld_o      (vld_o),
    .pos_o      (pos_o),
    .u_vec_o    (u_vec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input int p, input int base, input int step);
    hit_mask[l] = 1'b1;
    pos_bus[l]  = 10'(p);
    for (int k = 0; k < 12; k++) u_vec[l][k] = 10'(base + step * k);
  endtask

  // Expected reversal: u_vec_o[k] = u^(11-k) = base + step*(11-k).
  task automatic check_item(input string tag, input int p, input int base, input int step);
    $display("item %s: vld=%0d pos=0x%0h u[0]=0x%0h", tag, vld_o, pos_o, u_vec_o[0]);
    check({tag, " vld"}, vld_o, 1);
    check({tag, " pos"}, pos_o, p);
    for (int k = 0; k < 12; k++)
      check($sformatf("%s u[%0d]", tag, k), u_vec_o[k], (base + step * (11 - k)) & 32'h3FF);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hit_mask = '0; pos_bus = '0; u_vec = '0; s1_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset vld", vld_o, 0);
    check("reset pos", pos_o, 0);
    check("reset u0", u_vec_o[0], 0);
    check("reset u11", u_vec_o[11], 0);
    tick();
    check("idle vld", vld_o, 0);

    // Single lane 31
    set_lane(31, 'h155, 'h155, 1);
    tick(); hit_mask = '0;
    check("single N", vld_o, 0);
    tick();
    check("single N+1", vld_o, 0);
    tick();
    check_item("single", 'h155, 'h155, 1);
    tick(); check("single after", vld_o, 0);
    tick(); check("single after2", vld_o, 0);

    // Two lanes same cycle: 28 before 3
    set_lane(28, 'h2A0, 'h2A0, 3);
    set_lane(3, 'h035, 'h035, 5);
    tick(); hit_mask = '0;
    tick(); check("two N+1", vld_o, 0);
    tick(); check_item("two l28", 'h2A0, 'h2A0, 3);
    tick(); check_item("two l3", 'h035, 'h035, 5);
    tick(); check("two after", vld_o, 0);

    // Back-to-back events
    set_lane(5, 'h111, 'h111, 1);
    set_lane(2, 'h222, 'h222, 1);
    set_lane(1, 'h333, 'h333, 1);
    tick(); hit_mask = '0;
    set_lane(31, 'h3E7, 'h3E7, 1);
    tick(); hit_mask = '0;
    tick(); check_item("b2b 0", 'h111, 'h111, 1);
    tick(); check_item("b2b 1", 'h222, 'h222, 1);
    tick(); check_item("b2b 2", 'h333, 'h333, 1);
    tick(); check_item("b2b 3", 'h3E7, 'h3E7, 1);
    tick(); check("b2b after", vld_o, 0);

    // Backpressure: first item held while ready is low
    s1_rdy = 1'b0;
    set_lane(7, 'h0A1, 'h0A1, 2);
    set_lane(6, 'h0B2, 'h0B2, 2);
    set_lane(4, 'h0C3, 'h0C3, 2);
    tick(); hit_mask = '0;
    tick(); tick();
    check_item("bp first", 'h0A1, 'h0A1, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_item($sformatf("bp hold%0d", c), 'h0A1, 'h0A1, 2);
    end
    s1_rdy = 1'b1;
    tick(); check_item("bp 1", 'h0B2, 'h0B2, 2);
    tick(); check_item("bp 2", 'h0C3, 'h0C3, 2);
    tick(); check("bp after", vld_o, 0);

    // Overflow: 18 events on lane 0 with ready low; 16 FIFO + 1 output register survive
    s1_rdy = 1'b0;
    for (int p = 0; p < 18; p++) begin
      hit_mask = '0;
      set_lane(0, p, p, 1);
      tick();
    end
    hit_mask = '0;
    check_item("ovf 0", 0, 0, 1);
    s1_rdy = 1'b1;
    for (int p = 1; p < 17; p++) begin
      tick();
      check_item($sformatf("ovf %0d", p), p, p, 1);
    end
    tick(); check("ovf dropped", vld_o, 0);
    tick(); check("ovf idle", vld_o, 0);

    // Flush mid-stream; hits in the flush cycle are ignored
    set_lane(9, 'h101, 'h101, 1);
    set_lane(8, 'h102, 'h102, 1);
    tick(); hit_mask = '0;
    set_lane(10, 'h103, 'h103, 1);
    tick(); hit_mask = '0;
    set_lane(11, 'h104, 'h104, 1);
    tick(); hit_mask = '0;
    check_item("fl first", 'h101, 'h101, 1);
    flush = 1'b1;
    set_lane(12, 'h1AA, 'h1AA, 1);
    tick(); flush = 1'b0; hit_mask = '0;
    check("fl vld", vld_o, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("fl quiet%0d", c), vld_o, 0);
    end
    set_lane(0, 'h3FF, 'h3F0, 1);
    tick(); hit_mask = '0;
    tick(); check("fl new N+1", vld_o, 0);
    tick(); check_item("fl new", 'h3FF, 'h3F0, 1);
    tick(); check("fl new after", vld_o, 0);

    // Reset discards a held output item
    s1_rdy = 1'b0;
    set_lane(2, 'h2B4, 'h2B4, 1);
    tick(); hit_mask = '0;
    tick(); tick();
    check_item("rst held", 'h2B4, 'h2B4, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; s1_rdy = 1'b1;
    check("rst vld", vld_o, 0);
    check("rst pos", pos_o, 0);
    check("rst u0", u_vec_o[0], 0);
    tick(); tick();
    check("rst quiet", vld_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
